// File: rtl/execute_pipe.sv
// Registered execute stage: single-cycle ALU, iterative unsigned multiply/divide
// with HI/LO, and a valid/ready EX/MEM output slot.
`timescale 1ns/1ps
module execute_pipe #(
    parameter int DATA_W  = 32,
    parameter int REG_W   = 5,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_fun,
    input  logic [DATA_W-1:0] input_a,
    input  logic [DATA_W-1:0] input_sz,
    input  logic [DATA_W-1:0] input_register,
    input  logic [REG_W-1:0]  rt,
    input  logic [REG_W-1:0]  rd,
    input  logic              sel_alu,
    input  logic              sel_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_dato_registro,
    output logic [REG_W-1:0]  out_mux_sel_reg,
    output logic              out_dz,
    output logic              busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;
    localparam int CNT_W = $clog2(DATA_W) + 1;

    logic [1:0]          state;
    logic [DATA_W-1:0]   hi, lo;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] acc, mcand;
    // Multiplier bits (shifted right) during MUL; dividend in / quotient out during DIV.
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   rem, divisor;
    logic                op_div;
    logic [DATA_W-1:0]   pend_dato;
    logic [REG_W-1:0]    pend_dest;
    logic                pend_dz;

    logic [DATA_W-1:0]   b;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept, slot_free, is_mul, is_div, wb_load;
    logic [DATA_W:0]     div_shift, div_diff;
    logic [DATA_W-1:0]   alu_res, wb_hi, wb_lo;

    assign b         = sel_alu ? input_sz : input_register;
    assign shamt     = input_a[SHAMT_W-1:0];
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == ST_IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign is_mul    = (alu_fun == 4'b1011);
    assign is_div    = (alu_fun == 4'b1100);
    assign busy      = (state != ST_IDLE);
    assign wb_load   = (state == ST_WB) && slot_free;
    assign wb_hi     = op_div ? rem   : acc[2*DATA_W-1:DATA_W];
    assign wb_lo     = op_div ? shreg : acc[DATA_W-1:0];

    // Restoring step: the top bit of div_diff is the borrow, clear when the divisor fits.
    assign div_shift = {rem, shreg[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, divisor};

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves alu_res unassigned (no latch).
        alu_res = '0;
        case (alu_fun)
            4'b0001: alu_res = input_a + b;
            4'b0010: alu_res = input_a - b;
            4'b0011: alu_res = input_a & b;
            4'b0100: alu_res = input_a | b;
            4'b0101: alu_res = ~(input_a | b);
            4'b0110: alu_res = {{(DATA_W-1){1'b0}}, (input_a < b)};
            4'b0111: alu_res = {{(DATA_W-1){1'b0}}, ($signed(input_a) < $signed(b))};
            4'b1000: alu_res = b << shamt;
            4'b1001: alu_res = b >> shamt;
            4'b1010: alu_res = $signed(b) >>> shamt;
            4'b1101: alu_res = hi;
            4'b1110: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            hi                <= '0;
            lo                <= '0;
            out_valid         <= 1'b0;
            out_alu           <= '0;
            out_dato_registro <= '0;
            out_mux_sel_reg   <= '0;
            out_dz            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && is_mul)      state <= ST_MUL;
                    else if (accept && is_div) state <= ST_DIV;
                end
                // Counter reaches zero on this edge.
                ST_MUL, ST_DIV: if (count == CNT_W'(1)) state <= ST_WB;
                ST_WB: begin
                    if (slot_free) begin
                        state <= ST_IDLE;
                        hi    <= wb_hi;
                        lo    <= wb_lo;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (accept && !is_mul && !is_div) begin
                out_valid         <= 1'b1;
                out_alu           <= alu_res;
                out_dato_registro <= input_register;
                out_mux_sel_reg   <= sel_reg ? rd : rt;
                out_dz            <= 1'b0;
            end else if (wb_load) begin
                out_valid         <= 1'b1;
                out_alu           <= wb_lo;
                out_dato_registro <= pend_dato;
                out_mux_sel_reg   <= pend_dest;
                out_dz            <= pend_dz;
            end else if (out_ready) begin
                out_valid         <= 1'b0;
            end
        end
    end

    // NOTE: iteration datapath carries no reset; it is always loaded on accept before it is read.
    always_ff @(posedge clk) begin
        if (accept && (is_mul || is_div)) begin
            count     <= CNT_W'(DATA_W);
            op_div    <= is_div;
            mcand     <= {{DATA_W{1'b0}}, input_a};
            shreg     <= is_mul ? b : input_a;
            acc       <= '0;
            rem       <= '0;
            divisor   <= b;
            pend_dato <= input_register;
            pend_dest <= sel_reg ? rd : rt;
            pend_dz   <= is_div && (b == '0);
        end else if (state == ST_MUL) begin
            if (shreg[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            shreg <= shreg >> 1;
            count <= count - CNT_W'(1);
        end else if (state == ST_DIV) begin
            shreg <= {shreg[DATA_W-2:0], !div_diff[DATA_W]};
            rem   <= div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_execute_pipe.sv
// Randomized self-checking bench for execute_pipe against an arithmetic reference
// model holding its own HI/LO.
`timescale 1ns/1ps
module tb_execute_pipe;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int SW = $clog2(DW);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    alu_fun = '0;
    logic [DW-1:0] input_a = '0, input_sz = '0, input_register = '0;
    logic [RW-1:0] rt = '0, rd = '0;
    logic          sel_alu = 1'b0, sel_reg = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_alu, out_dato_registro;
    logic [RW-1:0] out_mux_sel_reg;
    logic          out_dz, busy;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] m_hi = '0, m_lo = '0;

    // waits: negedges sampled after the accepting edge until out_valid is seen.
    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] dato;
        logic [RW-1:0] sel;
        logic          dz;
        logic [7:0]    waits;
        logic [7:0]    busy_bad;
        logic          busy_end;
    } res_t;

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    execute_pipe #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_fun(alu_fun), .input_a(input_a), .input_sz(input_sz),
        .input_register(input_register), .rt(rt), .rd(rd),
        .sel_alu(sel_alu), .sel_reg(sel_reg), .out_valid(out_valid),
        .out_ready(out_ready), .out_alu(out_alu),
        .out_dato_registro(out_dato_registro), .out_mux_sel_reg(out_mux_sel_reg),
        .out_dz(out_dz), .busy(busy)
    );

    task automatic model_op(input logic [3:0] op, input logic [DW-1:0] a, sz, rg,
                            input logic [RW-1:0] t, d, input logic sa, sr, output res_t e);
        logic [DW-1:0]   bb;
        logic [2*DW-1:0] p;
        bb = sa ? sz : rg;
        e = '0;
        e.dato  = rg;
        e.sel   = sr ? d : t;
        e.waits = (op == 4'd11 || op == 4'd12) ? 8'(DW + 2) : 8'd1;
        case (op)
            4'd1:  e.alu = a + bb;
            4'd2:  e.alu = a - bb;
            4'd3:  e.alu = a & bb;
            4'd4:  e.alu = a | bb;
            4'd5:  e.alu = ~(a | bb);
            4'd6:  e.alu = (a < bb) ? DW'(1) : DW'(0);
            4'd7:  e.alu = ($signed(a) < $signed(bb)) ? DW'(1) : DW'(0);
            4'd8:  e.alu = bb << a[SW-1:0];
            4'd9:  e.alu = bb >> a[SW-1:0];
            4'd10: e.alu = $signed(bb) >>> a[SW-1:0];
            4'd11: begin
                p = {{DW{1'b0}}, a} * {{DW{1'b0}}, bb};
                m_hi = p[2*DW-1:DW];
                m_lo = p[DW-1:0];
                e.alu = m_lo;
            end
            4'd12: begin
                if (bb == '0) begin
                    m_lo = '1;
                    m_hi = a;
                    e.dz = 1'b1;
                end else begin
                    m_lo = a / bb;
                    m_hi = a % bb;
                end
                e.alu = m_lo;
            end
            4'd13: e.alu = m_hi;
            4'd14: e.alu = m_lo;
            default: e.alu = '0;
        endcase
    endtask

    task automatic send(input logic [3:0] op, input logic [DW-1:0] a, sz, rg,
                        input logic [RW-1:0] t, d, input logic sa, sr);
        int n;
        @(negedge clk);
        alu_fun = op; input_a = a; input_sz = sz; input_register = rg;
        rt = t; rd = d; sel_alu = sa; sel_reg = sr; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_accept: in_ready=%b required 1 after %0d cycles", in_ready, n);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic collect(output res_t o);
        int n;
        int bad;
        @(negedge clk);
        n = 1;
        bad = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        o.alu      = out_alu;
        o.dato     = out_dato_registro;
        o.sel      = out_mux_sel_reg;
        o.dz       = out_dz;
        o.waits    = 8'(n);
        o.busy_bad = 8'(bad);
        o.busy_end = busy;
    endtask

    task automatic exec_op(input logic [3:0] op, input logic [DW-1:0] a, sz, rg,
                           input logic [RW-1:0] t, d, input logic sa, sr,
                           output res_t o, output res_t e);
        model_op(op, a, sz, rg, t, d, sa, sr, e);
        send(op, a, sz, rg, t, d, sa, sr);
        collect(o);
    endtask

    task automatic test_reset;
        res_t o, e;
        logic [6+DW+DW+RW-1:0] got;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        got = {out_valid, busy, in_ready, out_dz, out_alu, out_dato_registro, out_mux_sel_reg, 2'b00};
        checks++;
        if (got !== {4'b0010, {DW{1'b0}}, {DW{1'b0}}, {RW{1'b0}}, 2'b00}) begin
            failures++;
            $display("FAIL reset_state: got %h required valid=0 busy=0 ready=1 data=0", got);
        end
        m_hi = '0;
        m_lo = '0;
        exec_op(4'd13, '0, '0, 32'h1234, 5'd1, 5'd2, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_mfhi: got %h required %h", o, e); end
        exec_op(4'd14, '0, '0, 32'h5678, 5'd3, 5'd4, 1'b0, 1'b1, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL reset_mflo: got %h required %h", o, e); end
    endtask

    task automatic test_plan_ops;
        res_t o, e;
        exec_op(4'd1, 32'hFFFFFFFF, 32'h0, 32'h1, 5'd3, 5'd9, 1'b0, 1'b1, o, e);
        checks++;
        if (o !== e || o.alu !== 32'h0 || o.sel !== 5'd9) begin
            failures++; $display("FAIL add_wrap: got %h required %h", o, e);
        end
        exec_op(4'd7, 32'hFFFFFFFE, 32'h3, 32'h0, 5'd4, 5'd5, 1'b1, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL slt_signed: got %h required %h", o, e); end
        exec_op(4'd6, 32'hFFFFFFFE, 32'h3, 32'h0, 5'd4, 5'd5, 1'b1, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL sltu_unsigned: got %h required %h", o, e); end
        exec_op(4'd10, 32'h4, 32'h80000000, 32'h7, 5'd6, 5'd7, 1'b1, 1'b1, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL sra_sign: got %h required %h", o, e); end
    endtask

    task automatic test_random_alu;
        res_t o, e;
        logic [3:0] op;
        logic [DW-1:0] a;
        for (int i = 0; i < 40; i++) begin
            do op = 4'($urandom_range(0, 15)); while (op == 4'd11 || op == 4'd12);
            a = (i % 2 == 0) ? DW'($urandom_range(0, DW - 1)) : DW'($urandom);
            exec_op(op, a, DW'($urandom), DW'($urandom), RW'($urandom), RW'($urandom),
                    1'($urandom), 1'($urandom), o, e);
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL random_alu op=%0d: got %h required %h", op, o, e);
            end
        end
    endtask

    task automatic test_multu;
        res_t o, e;
        exec_op(4'd11, 32'hFFFFFFFF, 32'h0, 32'h2, 5'd1, 5'd2, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL multu_plan: got %h required %h", o, e); end
        exec_op(4'd13, '0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL multu_mfhi: got %h required %h", o, e); end
        exec_op(4'd14, '0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL multu_mflo: got %h required %h", o, e); end
        for (int i = 0; i < 3; i++) begin
            exec_op(4'd11, DW'($urandom), DW'($urandom), DW'($urandom), RW'($urandom), RW'($urandom),
                    1'($urandom), 1'($urandom), o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL multu_random: got %h required %h", o, e); end
            exec_op(4'd13, '0, '0, DW'($urandom), RW'($urandom), RW'($urandom), 1'b0, 1'b0, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL multu_random_hi: got %h required %h", o, e); end
        end
    endtask

    task automatic test_divu;
        res_t o, e;
        exec_op(4'd12, 32'd7, 32'd0, 32'd9, 5'd1, 5'd2, 1'b1, 1'b1, o, e);
        checks++;
        if (o !== e || o.dz !== 1'b1) begin failures++; $display("FAIL divu_zero: got %h required %h", o, e); end
        exec_op(4'd13, '0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL divu_zero_hi: got %h required %h", o, e); end
        exec_op(4'd12, 32'd100, 32'd0, 32'd7, 5'd3, 5'd4, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL divu_100_7: got %h required %h", o, e); end
        exec_op(4'd13, '0, '0, '0, 5'd0, 5'd0, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL divu_hi: got %h required %h", o, e); end
        for (int i = 0; i < 3; i++) begin
            exec_op(4'd12, DW'($urandom), DW'($urandom_range(1, 1000)), DW'($urandom),
                    RW'($urandom), RW'($urandom), 1'b1, 1'($urandom), o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL divu_random: got %h required %h", o, e); end
            exec_op(4'd13, '0, '0, '0, RW'($urandom), RW'($urandom), 1'b0, 1'b0, o, e);
            checks++;
            if (o !== e) begin failures++; $display("FAIL divu_random_hi: got %h required %h", o, e); end
        end
    endtask

    task automatic test_back_to_back;
        res_t e1, e2;
        logic [DW-1:0] a1, r1, a2, r2;
        logic [1+1+DW+RW+DW-1:0] got, req;
        a1 = DW'($urandom); r1 = DW'($urandom);
        a2 = DW'($urandom); r2 = DW'($urandom);
        model_op(4'd1, a1, '0, r1, 5'd10, 5'd11, 1'b0, 1'b1, e1);
        model_op(4'd1, a2, '0, r2, 5'd12, 5'd13, 1'b0, 1'b0, e2);
        @(negedge clk);
        out_ready = 1'b0;
        send(4'd1, a1, '0, r1, 5'd10, 5'd11, 1'b0, 1'b1);
        alu_fun = 4'd1; input_a = a2; input_sz = '0; input_register = r2;
        rt = 5'd12; rd = 5'd13; sel_alu = 1'b0; sel_reg = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            got = {out_valid, in_ready, out_alu, out_mux_sel_reg, out_dato_registro};
            req = {1'b1, 1'b0, e1.alu, e1.sel, e1.dato};
            checks++;
            if (got !== req) begin failures++; $display("FAIL b2b_hold: got %h required %h", got, req); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        got = {out_valid, 1'b0, out_alu, out_mux_sel_reg, out_dato_registro};
        req = {1'b1, 1'b0, e2.alu, e2.sel, e2.dato};
        checks++;
        if (got !== req) begin failures++; $display("FAIL b2b_second: got %h required %h", got, req); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain: out_valid=%b required 0", out_valid); end
    endtask

    task automatic test_reset_abort;
        res_t o, e;
        send(4'd11, 32'hDEADBEEF, '0, 32'h12345678, 5'd1, 5'd2, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({busy, out_valid, in_ready} !== 3'b001) begin
            failures++;
            $display("FAIL abort_state: busy/valid/ready=%b required 001", {busy, out_valid, in_ready});
        end
        m_hi = '0;
        m_lo = '0;
        exec_op(4'd13, '0, '0, '0, 5'd1, 5'd1, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL abort_mfhi: got %h required %h", o, e); end
        exec_op(4'd14, '0, '0, '0, 5'd1, 5'd1, 1'b0, 1'b0, o, e);
        checks++;
        if (o !== e) begin failures++; $display("FAIL abort_mflo: got %h required %h", o, e); end
    endtask

    initial begin
        test_reset();
        test_plan_ops();
        test_random_alu();
        test_multu();
        test_divu();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
